// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a host payload, then sends header, payload and parity to the router.
// Optional build macro PKT_TX_ERR_INJECT_EN adds the inj_err port, which sends an inverted parity byte.
module router_pkt_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       busy,
  input  logic       error,
`ifdef PKT_TX_ERR_INJECT_EN
  input  logic       inj_err,
`endif
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       start_err,
  output logic [7:0] err_cnt
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  state_t                    state;
  logic        [1:0]         addr_q;
  logic        [5:0]         len_q;
  logic        [5:0]         wr_ptr;
  logic        [5:0]         rd_ptr;
  logic        [DATA_W-1:0]  parity;
  logic        [DATA_W-1:0]  pay_buf [64];
  logic                      err_prev;
  logic                      req_ok;
  logic        [DATA_W-1:0]  parity_tx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req_ok = (dest_addr != 2'd3) && (pay_len != 6'd0);

`ifdef PKT_TX_ERR_INJECT_EN
  logic inj_q;
  assign parity_tx = inj_q ? ~parity : parity;
`else
  assign parity_tx = parity;
`endif

  // Control path: state, pointers, parity accumulator, pulses and error counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      parity    <= '0;
      err_prev  <= 1'b0;
      err_cnt   <= '0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_err <= 1'b0;
      err_prev  <= error;
      if (error && !err_prev)
        err_cnt <= sat_inc(err_cnt);
      case (state)
        IDLE: if (start) begin
          if (!req_ok) begin
            start_err <= 1'b1;
          end else begin
            parity <= {pay_len, dest_addr};
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= LOAD;
          end
        end
        LOAD: if (src_valid) begin
          wr_ptr <= wr_ptr + 6'd1;
          parity <= parity ^ src_data;
          if (wr_ptr == len_q - 6'd1)
            state <= HEADER;
        end
        HEADER: if (!busy) begin
          rd_ptr <= '0;
          state  <= PAYLOAD;
        end
        PAYLOAD: if (!busy) begin
          if (rd_ptr == len_q - 6'd1)
            state <= PARITY;
          else
            rd_ptr <= rd_ptr + 6'd1;
        end
        PARITY: if (!busy) begin
          done  <= 1'b1;
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: request fields and payload buffer carry no reset
  always_ff @(posedge clock) begin
    if (state == IDLE && start && req_ok) begin
      addr_q <= dest_addr;
      len_q  <= pay_len;
`ifdef PKT_TX_ERR_INJECT_EN
      inj_q  <= inj_err;
`endif
    end
    if (state == LOAD && src_valid)
      pay_buf[wr_ptr] <= src_data;
  end

  // Output decode depends only on registered state, never on busy or error
  assign src_ready = (state == LOAD);
  assign tx_busy   = (state != IDLE);

  always_comb begin
    data_out  = '0;
    pkt_valid = 1'b0;
    case (state)
      HEADER: begin
        data_out  = {len_q, addr_q};
        pkt_valid = 1'b1;
      end
      PAYLOAD: begin
        data_out  = pay_buf[rd_ptr];
        pkt_valid = 1'b1;
      end
      PARITY:  data_out = parity_tx;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus random packets against a byte-stream model.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
  logic [7:0] src_data = '0;
  logic       src_valid = 1'b0;
  logic       busy = 1'b0;
  logic       error = 1'b0;
  logic       src_ready, pkt_valid, tx_busy, done, start_err;
  logic [7:0] data_out, err_cnt;
`ifdef PKT_TX_ERR_INJECT_EN
  logic       inj_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] pl [64];

  router_pkt_tx dut (
    .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
    .pay_len(pay_len), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .busy(busy), .error(error),
`ifdef PKT_TX_ERR_INJECT_EN
    .inj_err(inj_err),
`endif
    .data_out(data_out), .pkt_valid(pkt_valid), .tx_busy(tx_busy),
    .done(done), .start_err(start_err), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  // busy_mode: 0 never busy, 1 random busy plus stray starts, 2 stall 3 cycles on stream index 2.
  // abort_at >= 0 asserts reset when that stream index is on the output.
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] n, input int busy_mode,
                          input logic inj, input int abort_at);
    logic [7:0] stream [$];
    logic [7:0] par, exp_d;
    logic       exp_v, b;
    int idx, cyc, stall, seen22;
    stream = {};
    stream.push_back({n, a});
    for (int i = 0; i < n; i++) stream.push_back(pl[i]);
    par = 8'h00;
    foreach (stream[i]) par = par ^ stream[i];
    if (inj) par = ~par;

    @(negedge clock);
    start = 1'b1; dest_addr = a; pay_len = n;
`ifdef PKT_TX_ERR_INJECT_EN
    inj_err = inj;
`endif
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        src_valid = 1'b0;
        @(negedge clock);
      end
      checks++;
      if ({src_ready, tx_busy, pkt_valid} !== 3'b110) begin
        errors++;
        $display("FAIL load byte %0d: rdy/busy/pv got %b want 110", i, {src_ready, tx_busy, pkt_valid});
      end
      src_valid = 1'b1; src_data = pl[i];
      @(negedge clock);
    end
    src_valid = 1'b0;

    idx = 0; cyc = 0; stall = 0; seen22 = 0;
    while (idx <= n + 1 && cyc < 2000) begin
      exp_v = (idx <= n);
      exp_d = exp_v ? stream[idx] : par;
      checks++;
      if ({data_out, pkt_valid, src_ready, start_err, tx_busy} !== {exp_d, exp_v, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stream idx %0d: data/pv/rdy/serr/busy got %h %b%b%b%b want %h %b001",
                 idx, data_out, pkt_valid, src_ready, start_err, tx_busy, exp_d, exp_v);
      end
      if (idx == abort_at) begin
        reset = 1'b1; start = 1'b0; busy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({data_out, pkt_valid, tx_busy, src_ready, done, start_err} !== 13'd0) begin
          errors++;
          $display("FAIL abort reset: data/pv/busy/rdy/done/serr got %h %b%b%b%b%b want 00 00000",
                   data_out, pkt_valid, tx_busy, src_ready, done, start_err);
        end
        return;
      end
      b = 1'b0;
      if (busy_mode == 1) begin
        b = ($urandom_range(2) == 0);
        start = ($urandom_range(3) == 0);
        dest_addr = 2'd3;
        pay_len = 6'($urandom);
      end else if (busy_mode == 2 && idx == 2 && stall < 3) begin
        b = 1'b1;
        stall++;
      end
      if (busy_mode == 2 && exp_v && exp_d == 8'h22) seen22++;
      busy = b;
      @(negedge clock);
      if (!b) idx++;
      cyc++;
    end
    start = 1'b0; busy = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL stream timeout: idx %0d want %0d", idx, n + 2);
    end
    checks++;
    if ({data_out, pkt_valid, tx_busy, done, start_err} !== {8'h00, 4'b0110}) begin
      errors++;
      $display("FAIL gap: data/pv/busy/done/serr got %h %b%b%b%b want 00 0110",
               data_out, pkt_valid, tx_busy, done, start_err);
    end
    @(negedge clock);
    checks++;
    if ({data_out, pkt_valid, tx_busy, done, src_ready} !== 12'd0) begin
      errors++;
      $display("FAIL idle after gap: data/pv/busy/done/rdy got %h %b%b%b%b want 00 0000",
               data_out, pkt_valid, tx_busy, done, src_ready);
    end
    if (busy_mode == 2) begin
      checks++;
      if (seen22 != 4) begin
        errors++;
        $display("FAIL busy hold: 0x22 cycles got %0d want 4", seen22);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; dest_addr = 2'd1; pay_len = 6'd3;
    repeat (2) @(negedge clock);
    checks++;
    if ({data_out, pkt_valid, src_ready, tx_busy, done, start_err, err_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL reset: data/pv/rdy/busy/done/serr/cnt got %h %b%b%b%b%b %h want all 0",
               data_out, pkt_valid, src_ready, tx_busy, done, start_err, err_cnt);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    checks++;
    if ({tx_busy, src_ready, start_err} !== 3'b000) begin
      errors++;
      $display("FAIL after reset: busy/rdy/serr got %b want 000", {tx_busy, src_ready, start_err});
    end
  endtask

  task automatic test_basic();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 1'b0, -1);
  endtask

  task automatic test_busy_hold();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 2, 1'b0, -1);
  endtask

  task automatic test_start_err();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      start = 1'b1;
      dest_addr = (k == 0) ? 2'd3 : 2'd0;
      pay_len   = (k == 0) ? 6'd5 : 6'd0;
      @(negedge clock);
      start = 1'b0;
      checks++;
      if ({start_err, tx_busy, src_ready} !== 3'b100) begin
        errors++;
        $display("FAIL start_err case %0d: serr/busy/rdy got %b want 100", k, {start_err, tx_busy, src_ready});
      end
      @(negedge clock);
      checks++;
      if ({start_err, tx_busy, src_ready} !== 3'b000) begin
        errors++;
        $display("FAIL start_err pulse %0d: serr/busy/rdy got %b want 000", k, {start_err, tx_busy, src_ready});
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
      send_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 1, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    send_pkt(2'd2, 6'd5, 0, 1'b0, 3);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 1'b0, -1);
  endtask

  task automatic test_err_cnt();
    int   cnt;
    logic prev, e;
    logic seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      error = seq[i];
    end
    @(negedge clock);
    checks++;
    if (err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL err_cnt pattern: got %0d want 2", err_cnt);
    end
    cnt = 2;
    for (int i = 0; i < 300; i++) begin
      error = 1'b1; @(negedge clock);
      error = 1'b0; @(negedge clock);
      if (i == 99) begin
        checks++;
        if (err_cnt !== 8'd102) begin
          errors++;
          $display("FAIL err_cnt mid: got %0d want 102", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt saturate: got %0d want 255", err_cnt);
    end
    // random error wave from a fresh reset, counted as rising edges
    @(negedge clock);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      e = ($urandom_range(1) == 1);
      error = e;
      if (e && !prev && cnt < 255) cnt++;
      prev = e;
      @(negedge clock);
    end
    error = 1'b0;
    checks++;
    if (err_cnt !== 8'(cnt)) begin
      errors++;
      $display("FAIL err_cnt random: got %0d want %0d", err_cnt, cnt);
    end
  endtask

`ifdef PKT_TX_ERR_INJECT_EN
  task automatic test_inject();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 1'b1, -1);
    inj_err = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_start_err();
    test_random();
    test_reset_mid();
    test_err_cnt();
`ifdef PKT_TX_ERR_INJECT_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- clock  input  1  sole clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a packet; sampled in IDLE only
- dest_addr  input  2  destination port 0..2
- pay_len  input  6  payload byte count 1..63
- src_data  input  8  host payload byte
- src_valid  input  1  src_data valid
- src_ready  output  1  block accepts src_data this cycle
- busy  input  1  router busy (hold current byte)
- error  input  1  router parity-error flag
- data_out  output  8  byte to router data_in
- pkt_valid  output  1  to router pkt_valid
- tx_busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when the parity byte is accepted
- start_err  output  1  one-cycle pulse when a start is rejected
- err_cnt  output  8  saturating count of router error events

Function
REQ-002 SHALL implement the states IDLE, LOAD, HEADER, PAYLOAD, PARITY and GAP.
REQ-003 In IDLE with start=1, a request with dest_addr!=3 and pay_len!=0 SHALL latch addr and len, set parity to header, and go to LOAD.
REQ-004 In IDLE with start=1, a request with dest_addr=3 or pay_len=0 SHALL pulse start_err for one cycle and remain in IDLE.
REQ-005 A start outside IDLE SHALL be ignored, with no start_err.
REQ-006 In LOAD, src_ready SHALL be 1.
REQ-007 In LOAD, each src_valid&src_ready edge SHALL write buf[wr_ptr] (64x8 register array), increment wr_ptr, and XOR the byte into parity.
REQ-008 Once the byte that makes the count equal len is accepted, the block SHALL go to HEADER; src_ready SHALL be 0 from that next cycle on.
REQ-009 The header byte SHALL be {len[5:0], addr[1:0]}.
REQ-010 In HEADER, data_out SHALL be the header and pkt_valid=1.
REQ-011 In PAYLOAD, data_out SHALL be buf[rd_ptr] and pkt_valid=1.
REQ-012 In PARITY, data_out SHALL be the parity byte and pkt_valid=0.
REQ-013 A presented byte is accepted at a rising edge with busy=0; with busy=1, state, pointers and data_out SHALL hold unchanged, for any number of cycles.
REQ-014 Acceptance SHALL move HEADER to PAYLOAD (rd_ptr=0); PAYLOAD to PAYLOAD (rd_ptr+1) until the last byte, then to PARITY; and PARITY to GAP with done=1.
REQ-015 GAP SHALL last exactly one cycle with data_out=0 and pkt_valid=0, then go to IDLE.
REQ-016 Parity SHALL be the XOR of the header and all payload bytes.
REQ-017 data_out, pkt_valid and src_ready SHALL be decoded from registered state only, with no combinational path from busy or error.
REQ-018 In IDLE, data_out SHALL be 0 and pkt_valid SHALL be 0.
REQ-019 err_cnt SHALL increment on each cycle where error=1 and the registered previous error=0, saturating at 255.

Reset
REQ-020 reset=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD and mid-PAYLOAD.
REQ-021 During reset, the block SHALL clear wr_ptr, rd_ptr, parity, err_cnt and the previous-error register.
REQ-022 After reset, data_out, pkt_valid, src_ready, tx_busy, done, start_err and err_cnt SHALL all be 0 from the next cycle; buffer contents are don't-care.
REQ-023 reset SHALL take priority over start.

Configuration
REQ-024 With PKT_TX_ERR_INJECT_EN defined, an input port inj_err (1 bit) SHALL exist and be latched with start; when latched 1, the parity byte SHALL be sent as ~parity.
REQ-025 Without PKT_TX_ERR_INJECT_EN, port inj_err SHALL be absent and parity SHALL always be correct.

Verification
REQ-026 addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, then done pulse, then one GAP cycle, then IDLE.
REQ-027 Same packet with busy=1 for 3 cycles while 0x22 is presented -> 0x22 stable for 4 cycles total, pkt_valid=1, rd_ptr unchanged.
REQ-028 start with addr=3, and separately start with len=0 -> start_err=1 for one cycle, tx_busy stays 0, src_ready stays 0.
REQ-029 reset asserted during PAYLOAD -> next cycle in IDLE with pkt_valid=0, data_out=0, tx_busy=0; a subsequent packet is correct.
REQ-030 error held high 2 cycles, low, then high 1 cycle -> err_cnt=2; 300 isolated error pulses -> err_cnt=255.
REQ-031 With PKT_TX_ERR_INJECT_EN defined and inj_err=1, the REQ-026 stimulus -> parity byte 0xF2.
